// File: rtl/serial_adder_unit.sv
// Bit-serial adder: drives the upstream operand shift registers and adds A + B + cin one bit per cycle, LSB first.
// The sum and carry-out are presented together with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// LOAD  | upstream registers parallel-load; carry, counter and sum are cleared
// ADD   | one sum bit per cycle for WIDTH cycles
// DONE  | sum/cout valid, done pulses for one cycle
module serial_adder_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cin,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             load_mode,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ADD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic             carry;
    logic             bit_sum;
    logic             bit_carry;

    assign bit_sum   = a_bit ^ b_bit ^ carry;
    assign bit_carry = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            carry   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    carry   <= cin;
                    counter <= '0;
                    sum     <= '0;
                    state   <= ADD;
                end
                ADD: begin
                    sum     <= {bit_sum, sum[WIDTH-1:1]};
                    carry   <= bit_carry;
                    counter <= counter + 1'b1;
                    if (counter == LAST_BIT) begin
                        cout  <= bit_carry;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so they are glitch-free and clear with reset.
    assign load_mode = (state == LOAD);
    assign busy      = (state == LOAD) || (state == ADD);
    assign done      = (state == DONE);

endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
- Bit-serial adder stage directly downstream of the two 8-bit parallel-load shift registers that hold operands A and B.
- Drives their mode (load/shift) line and consumes one bit per cycle from each serialOut, LSB first.
- Accumulates the sum into an internal result shift register and carry flop.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an addition; sampled only in IDLE.
- cin  input  1  carry-in; captured in the LOAD cycle.
- a_bit  input  1  serial bit of operand A from the upstream shift register, LSB first.
- b_bit  input  1  serial bit of operand B from the upstream shift register, LSB first.
- load_mode  output  1  drives the upstream shift registers' mode: 1 = parallel load, 0 = shift.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.
- busy  output  1  high in LOAD and ADD.
- done  output  1  one-cycle pulse when sum/cout become valid.

Behaviour:
- Reset (asynchronous, active-high, dominant over everything):
  - state=IDLE, sum=0, cout=0, carry=0, counter=0.
  - load_mode=0, busy=0, done=0.
- FSM states: IDLE, LOAD, ADD, DONE.
- IDLE:
  - load_mode=0, busy=0.
  - start=1 -> LOAD.
  - sum/cout keep their last values.
- LOAD (exactly 1 cycle):
  - load_mode=1, busy=1.
  - carry<=cin, counter<=0, sum<=0 at the exiting edge.
  - -> ADD.
- ADD (exactly WIDTH cycles):
  - load_mode=0, busy=1.
  - Each rising edge: s=a_bit^b_bit^carry; carry<=majority(a_bit,b_bit,carry); sum<={s,sum[WIDTH-1:1]}; counter<=counter+1.
  - Bit i of each operand is sampled at the (i+1)-th ADD edge.
  - When counter==WIDTH-1 at an edge, that edge performs the final bit and transitions -> DONE.
  - cout<=final carry on that same edge.
- DONE (1 cycle):
  - done=1, busy=0, load_mode=0.
  - -> IDLE unconditionally.
  - start in DONE is ignored; it must be held or re-asserted in IDLE.
- Latency: start sampled at edge k -> load_mode high in cycle k..k+1 -> done high in the cycle after edge k+1+WIDTH. For WIDTH=8: done is high 10 cycles after start is sampled.
- start asserted during LOAD/ADD/DONE: ignored; no restart, no error.
- Outputs:
  - sum and cout are stable from DONE until the next LOAD exit edge.
  - Outputs are valid only while done=1 or in the IDLE that follows.
- Arithmetic: {cout,sum} = A + B + cin modulo 2^(WIDTH+1). No overflow flag; signed interpretation is the consumer's concern.
- Reset mid-operation (any state): immediate return to reset values; partial sum discarded; no done pulse. Upstream registers must be reloaded by a new start.
- a_bit/b_bit values outside ADD have no effect.

Test Plan:
- Reset, then start=1 one cycle, A=9, B=28, cin=0 -> load_mode high one cycle; done after 10 cycles; sum=37 (0x25), cout=0; busy low in DONE.
- A=255, B=1, cin=0 -> sum=0x00, cout=1.
- A=200, B=100, cin=1 -> sum=45 (0x2D), cout=1.
- Start at A=9, B=28; assert reset for one cycle at the 4th ADD cycle -> sum=0, cout=0, busy=0, no done. Restart with A=28, B=28 -> sum=56, cout=0.
- Hold start high continuously -> one addition per WIDTH+3 cycles (LOAD, 8×ADD, DONE, IDLE); start pulses during busy cause no extra load_mode pulses.
- Back-to-back A=0, B=0, cin=0 after a cout=1 result -> stale carry cleared; sum=0, cout=0.
